// File: rtl/rr_bus_sched.sv
// Round-robin scheduler for a shared broadcast bus: grants one pending driver FIFO
// at a time, pops its head packet and pushes it to one destination or broadcasts it.
module rr_bus_sched #(
  parameter int         drvrs   = 4,
  parameter int         pckg_sz = 16,
  parameter logic [7:0] bdcst   = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic                     busy,
  output logic [3:0]               grant_id,
  output logic [7:0]               drop_cnt
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [IW-1:0]        gidx_reg, gidx_next;
  logic [drvrs-1:0]     pop_reg, pop_next;
  logic [drvrs-1:0]     push_reg, push_next;
  logic [pckg_sz-1:0]   d_push_reg, d_push_next;
  logic [7:0]           drop_reg, drop_next;

  logic [pckg_sz-1:0]   heads [drvrs];
  logic [pckg_sz-1:0]   head_sel;
  logic [7:0]           dest;
  logic [IW-1:0]        sel_idx;
  logic                 sel_found;
  logic [drvrs-1:0]     sel_onehot;
  logic [drvrs-1:0]     uni_dec;
  logic [drvrs-1:0]     bc_dec;

  // Per-driver views of the FIFO heads and the per-bit decode vectors.
  generate
    for (genvar gi = 0; gi < drvrs; gi++) begin : g_drv
      assign heads[gi]      = D_pop[gi*pckg_sz +: pckg_sz];
      assign sel_onehot[gi] = (sel_idx == IW'(gi));
      assign uni_dec[gi]    = (dest == 8'(gi));
      assign bc_dec[gi]     = (gidx_reg != IW'(gi));
    end
  endgenerate

  assign head_sel = heads[gidx_reg];
  assign dest     = head_sel[pckg_sz-1 -: 8];

  // Search starts just after the last grant so the previous winner goes last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= drvrs; k++) begin
      int idx;
      idx = (int'(gidx_reg) + k) % drvrs;
      if (!sel_found && pndng[idx]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    gidx_next   = gidx_reg;
    pop_next    = '0;
    push_next   = '0;
    d_push_next = d_push_reg;
    drop_next   = drop_reg;
    case (state_reg)
      IDLE: begin
        if (|pndng) begin
          gidx_next  = sel_idx;
          pop_next   = sel_onehot;
          state_next = POP;
        end
      end
      POP: begin
        // A head that vanished before the pop is abandoned without a transfer.
        if (pndng[gidx_reg]) begin
          d_push_next = head_sel;
          state_next  = PUSH;
          if (dest < 8'(drvrs)) begin
            push_next = uni_dec;
          end else if (dest == bdcst) begin
            push_next = bc_dec;
          end else if (drop_reg != 8'hFF) begin
            drop_next = drop_reg + 8'd1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      PUSH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      gidx_reg   <= IW'(drvrs - 1);
      pop_reg    <= '0;
      push_reg   <= '0;
      d_push_reg <= '0;
      drop_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      gidx_reg   <= gidx_next;
      pop_reg    <= pop_next;
      push_reg   <= push_next;
      d_push_reg <= d_push_next;
      drop_reg   <= drop_next;
    end
  end

  // Pulses are masked by reset and by a missing head so an aborted cycle never pops or pushes.
  assign pop      = reset ? '0 : (pop_reg & pndng);
  assign push     = reset ? '0 : push_reg;
  assign D_push   = d_push_reg;
  assign busy     = (state_reg != IDLE);
  assign grant_id = 4'(gidx_reg);
  assign drop_cnt = drop_reg;

endmodule

// File: tb/tb_rr_bus_sched.sv
// Directed bench for rr_bus_sched: reset, unicast, round-robin order, broadcast,
// invalid-destination drop, reset during PUSH and drop counter saturation.
module tb_rr_bus_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] d_pop;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [15:0] d_push;
  logic        busy;
  logic [3:0]  grant_id;
  logic [7:0]  drop_cnt;

  int vectors;
  int errors;

  rr_bus_sched dut (
    .clk(clk),
    .reset(reset),
    .pndng(pndng),
    .D_pop(d_pop),
    .pop(pop),
    .push(push),
    .D_push(d_push),
    .busy(busy),
    .grant_id(grant_id),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pndng = 4'h0;
    d_pop = '0;
    repeat (3) nxt();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pndng = 4'hF;
    d_pop = 64'h0123_4567_89AB_CDEF;
    repeat (5) nxt();
    vectors++; if (pop !== 4'b0000) begin errors++; $display("FAIL reset_pop got %b exp %b", pop, 4'b0000); end
    vectors++; if (push !== 4'b0000) begin errors++; $display("FAIL reset_push got %b exp %b", push, 4'b0000); end
    vectors++; if (d_push !== 16'h0000) begin errors++; $display("FAIL reset_dpush got %h exp %h", d_push, 16'h0000); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp %b", busy, 1'b0); end
    vectors++; if (grant_id !== 4'd3) begin errors++; $display("FAIL reset_grant got %0d exp %0d", grant_id, 3); end
    vectors++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop got %h exp %h", drop_cnt, 8'h00); end
    reset = 1'b0;
    pndng = 4'h0;
    $display("test_reset: outputs checked after 5 reset cycles");
  endtask

  task automatic test_unicast();
    pndng = 4'b0010;
    d_pop[16 +: 16] = 16'h02AB;
    nxt();
    vectors++; if (pop !== 4'b0010) begin errors++; $display("FAIL uni_pop got %b exp %b", pop, 4'b0010); end
    vectors++; if (grant_id !== 4'd1) begin errors++; $display("FAIL uni_grant got %0d exp %0d", grant_id, 1); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL uni_busy got %b exp %b", busy, 1'b1); end
    nxt();
    vectors++; if (push !== 4'b0100) begin errors++; $display("FAIL uni_push got %b exp %b", push, 4'b0100); end
    vectors++; if (d_push !== 16'h02AB) begin errors++; $display("FAIL uni_dpush got %h exp %h", d_push, 16'h02AB); end
    vectors++; if (pop !== 4'b0000) begin errors++; $display("FAIL uni_pop_off got %b exp %b", pop, 4'b0000); end
    pndng = 4'h0;
    nxt();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL uni_idle got %b exp %b", busy, 1'b0); end
    vectors++; if (push !== 4'b0000) begin errors++; $display("FAIL uni_push_off got %b exp %b", push, 4'b0000); end
    vectors++; if (d_push !== 16'h02AB) begin errors++; $display("FAIL uni_dpush_hold got %h exp %h", d_push, 16'h02AB); end
    nxt();
    vectors++; if (pop !== 4'b0000) begin errors++; $display("FAIL uni_stay_idle got %b exp %b", pop, 4'b0000); end
    $display("test_unicast: drv1 -> drv2 packet 02AB");
  endtask

  task automatic test_round_robin();
    logic [15:0] pkt [4];
    logic [3:0]  exp_push [4];
    logic [3:0]  exp_pop [4];
    pkt[0] = 16'h01A0; pkt[1] = 16'h02A1; pkt[2] = 16'h03A2; pkt[3] = 16'h00A3;
    exp_push[0] = 4'b0010; exp_push[1] = 4'b0100; exp_push[2] = 4'b1000; exp_push[3] = 4'b0001;
    exp_pop[0] = 4'b0001; exp_pop[1] = 4'b0010; exp_pop[2] = 4'b0100; exp_pop[3] = 4'b1000;
    do_reset();
    d_pop = {pkt[3], pkt[2], pkt[1], pkt[0]};
    pndng = 4'hF;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      nxt();
      vectors++; if (pop !== exp_pop[g]) begin errors++; $display("FAIL rr_pop[%0d] got %b exp %b", k, pop, exp_pop[g]); end
      vectors++; if (grant_id !== 4'(g)) begin errors++; $display("FAIL rr_grant[%0d] got %0d exp %0d", k, grant_id, g); end
      nxt();
      vectors++; if (push !== exp_push[g]) begin errors++; $display("FAIL rr_push[%0d] got %b exp %b", k, push, exp_push[g]); end
      vectors++; if (d_push !== pkt[g]) begin errors++; $display("FAIL rr_dpush[%0d] got %h exp %h", k, d_push, pkt[g]); end
      vectors++; if (pop !== 4'b0000) begin errors++; $display("FAIL rr_pop_push[%0d] got %b exp %b", k, pop, 4'b0000); end
      nxt();
      vectors++; if ({pop, push, busy} !== 9'b0) begin errors++; $display("FAIL rr_idle[%0d] got pop=%b push=%b busy=%b exp all 0", k, pop, push, busy); end
      $display("test_round_robin: packet %0d from drv%0d", k, g);
    end
    pndng = 4'h0;
  endtask

  task automatic test_broadcast_drop();
    do_reset();
    pndng = 4'b0100;
    d_pop[32 +: 16] = 16'hFF55;
    nxt();
    vectors++; if (pop !== 4'b0100) begin errors++; $display("FAIL bc_pop got %b exp %b", pop, 4'b0100); end
    nxt();
    vectors++; if (push !== 4'b1011) begin errors++; $display("FAIL bc_push got %b exp %b", push, 4'b1011); end
    vectors++; if (d_push !== 16'hFF55) begin errors++; $display("FAIL bc_dpush got %h exp %h", d_push, 16'hFF55); end
    pndng = 4'b0001;
    d_pop[0 +: 16] = 16'h0712;
    nxt();
    vectors++; if (pop !== 4'b0000) begin errors++; $display("FAIL drop_idle_pop got %b exp %b", pop, 4'b0000); end
    nxt();
    vectors++; if (pop !== 4'b0001) begin errors++; $display("FAIL drop_pop got %b exp %b", pop, 4'b0001); end
    vectors++; if (grant_id !== 4'd0) begin errors++; $display("FAIL drop_grant got %0d exp %0d", grant_id, 0); end
    nxt();
    vectors++; if (push !== 4'b0000) begin errors++; $display("FAIL drop_push got %b exp %b", push, 4'b0000); end
    vectors++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt got %0d exp %0d", drop_cnt, 1); end
    vectors++; if (d_push !== 16'h0712) begin errors++; $display("FAIL drop_dpush got %h exp %h", d_push, 16'h0712); end
    pndng = 4'h0;
    nxt();
    vectors++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_hold got %0d exp %0d", drop_cnt, 1); end
    $display("test_broadcast_drop: FF55 broadcast from drv2, 0712 dropped from drv0");
  endtask

  task automatic test_reset_in_push();
    do_reset();
    pndng = 4'b0001;
    d_pop[0 +: 16] = 16'h0100;
    nxt();
    vectors++; if (pop !== 4'b0001) begin errors++; $display("FAIL rp_pop got %b exp %b", pop, 4'b0001); end
    nxt();
    pndng = 4'h0;
    reset = 1'b1;
    #1;
    vectors++; if (push !== 4'b0000) begin errors++; $display("FAIL rp_push_masked got %b exp %b", push, 4'b0000); end
    nxt();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rp_busy got %b exp %b", busy, 1'b0); end
    vectors++; if (grant_id !== 4'd3) begin errors++; $display("FAIL rp_grant got %0d exp %0d", grant_id, 3); end
    vectors++; if (d_push !== 16'h0000) begin errors++; $display("FAIL rp_dpush got %h exp %h", d_push, 16'h0000); end
    vectors++; if (push !== 4'b0000) begin errors++; $display("FAIL rp_push got %b exp %b", push, 4'b0000); end
    reset = 1'b0;
    pndng = 4'hF;
    d_pop = {16'h0000, 16'h0000, 16'h0000, 16'h0200};
    nxt();
    vectors++; if (pop !== 4'b0001) begin errors++; $display("FAIL rp_restart_pop got %b exp %b", pop, 4'b0001); end
    vectors++; if (grant_id !== 4'd0) begin errors++; $display("FAIL rp_restart_grant got %0d exp %0d", grant_id, 0); end
    $display("test_reset_in_push: push suppressed, arbitration restarts at drv0");
  endtask

  task automatic test_drop_saturation();
    int push_seen;
    push_seen = 0;
    do_reset();
    pndng = 4'b0001;
    d_pop[0 +: 16] = 16'h0900;
    for (int n = 1; n <= 900; n++) begin
      nxt();
      if (push !== 4'b0000) push_seen++;
      if (n == 30) begin
        vectors++; if (drop_cnt !== 8'd10) begin errors++; $display("FAIL sat_drop10 got %0d exp %0d", drop_cnt, 10); end
      end
      if (n == 762) begin
        vectors++; if (drop_cnt !== 8'hFE) begin errors++; $display("FAIL sat_drop254 got %h exp %h", drop_cnt, 8'hFE); end
      end
    end
    vectors++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL sat_drop_final got %h exp %h", drop_cnt, 8'hFF); end
    vectors++; if (push_seen !== 0) begin errors++; $display("FAIL sat_no_push got %0d push cycles exp 0", push_seen); end
    pndng = 4'h0;
    $display("test_drop_saturation: 300 packets to dest 09");
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    pndng   = 4'h0;
    d_pop   = '0;
    test_reset();
    test_unicast();
    test_round_robin();
    test_broadcast_drop();
    test_reset_in_push();
    test_drop_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
